// File: rtl/alarm_sequencer.sv
// Alarm sequencer: turns the comparator's match level into a ringing session with a 1 Hz beep,
// ring timeout, bounded snooze and stop control.
module alarm_sequencer #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_1hz_i,
    input  logic       sound_alarm_i,
    input  logic       alarm_en_i,
    input  logic       snooze_btn_i,
    input  logic       stop_btn_i,
    output logic       buzzer_o,
    output logic       alarm_active_o,
    output logic       snoozing_o,
    output logic [2:0] snooze_cnt_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRinging,
        StSnooze
    } state_e;

    localparam logic [15:0] RingLast   = 16'(RING_SEC - 1);
    localparam logic [15:0] SnoozeLast = 16'(SNOOZE_SEC - 1);
    localparam logic [2:0]  MaxSnooze  = 3'(MAX_SNOOZE);

    state_e      state_q, state_d;
    logic        snd_q;
    logic [15:0] sec_cnt_q, sec_cnt_d;
    logic        beep_q, beep_d;
    logic [2:0]  snooze_cnt_q, snooze_cnt_d;
    logic        buzzer_q, buzzer_d;
    logic        trigger;

    // Rising edge of the match level; snd_q resets high so a level present at reset is ignored.
    assign trigger = sound_alarm_i & ~snd_q;

    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        beep_d       = beep_q;
        snooze_cnt_d = snooze_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (trigger && alarm_en_i) begin
                    state_d      = StRinging;
                    sec_cnt_d    = 16'd0;
                    snooze_cnt_d = 3'd0;
                    beep_d       = 1'b1;
                end
            end
            StRinging: begin
                if (stop_btn_i || !alarm_en_i) begin
                    state_d = StIdle;
                end else if (snooze_btn_i && (snooze_cnt_q < MaxSnooze)) begin
                    state_d      = StSnooze;
                    sec_cnt_d    = 16'd0;
                    snooze_cnt_d = snooze_cnt_q + 3'd1;
                end else if (tick_1hz_i) begin
                    if (sec_cnt_q == RingLast) begin
                        state_d = StIdle;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 16'd1;
                        beep_d    = ~beep_q;
                    end
                end
            end
            StSnooze: begin
                if (stop_btn_i || !alarm_en_i) begin
                    state_d = StIdle;
                end else if (tick_1hz_i) begin
                    if (sec_cnt_q == SnoozeLast) begin
                        state_d   = StRinging;
                        sec_cnt_d = 16'd0;
                        beep_d    = 1'b1;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        buzzer_d = (state_d == StRinging) & beep_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            snd_q        <= 1'b1;
            sec_cnt_q    <= 16'd0;
            beep_q       <= 1'b0;
            snooze_cnt_q <= 3'd0;
            buzzer_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            snd_q        <= sound_alarm_i;
            sec_cnt_q    <= sec_cnt_d;
            beep_q       <= beep_d;
            snooze_cnt_q <= snooze_cnt_d;
            buzzer_q     <= buzzer_d;
        end
    end

    assign buzzer_o       = buzzer_q;
    assign alarm_active_o = (state_q == StRinging);
    assign snoozing_o     = (state_q == StSnooze);
    assign snooze_cnt_o   = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: directed scenarios then random stimulus, checked against
// a session-level reference model.
module tb_alarm_sequencer;

    localparam int unsigned Ring  = 4;
    localparam int unsigned Snz   = 3;
    localparam int unsigned MaxSn = 2;

    logic       clk = 1'b0;
    logic       rst_n, tick, snd, en, snz_btn, stp_btn;
    logic       buzzer, active, snoozing;
    logic [2:0] cnt;

    always #5 clk = ~clk;

    alarm_sequencer #(
        .RING_SEC  (Ring),
        .SNOOZE_SEC(Snz),
        .MAX_SNOOZE(MaxSn)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tick_1hz_i    (tick),
        .sound_alarm_i (snd),
        .alarm_en_i    (en),
        .snooze_btn_i  (snz_btn),
        .stop_btn_i    (stp_btn),
        .buzzer_o      (buzzer),
        .alarm_active_o(active),
        .snoozing_o    (snoozing),
        .snooze_cnt_o  (cnt)
    );

    typedef struct packed {
        logic       buz;
        logic       act;
        logic       snoozing;
        logic [2:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    int   checks = 0;
    int   errors = 0;

    // Model: mode 0 idle, 1 ringing, 2 snoozing; elapsed = whole seconds spent in current phase.
    int m_mode    = 0;
    int m_elapsed = 0;
    int m_used    = 0;
    bit m_prev    = 1'b1;

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            check("buzzer", {2'b0, buzzer}, {2'b0, mon_x.buz});
            check("alarm_active", {2'b0, active}, {2'b0, mon_x.act});
            check("snoozing", {2'b0, snoozing}, {2'b0, mon_x.snoozing});
            check("snooze_cnt", cnt, mon_x.cnt);
        end
    end

    task automatic step(input bit r, input bit t, input bit s, input bit e, input bit z,
                        input bit p);
        exp_t x;
        bit   trig;
        rst_n = r; tick = t; snd = s; en = e; snz_btn = z; stp_btn = p;
        @(posedge clk);
        trig = s && !m_prev;
        if (!r) begin
            m_mode = 0; m_elapsed = 0; m_used = 0; m_prev = 1'b1;
        end else begin
            case (m_mode)
                0: if (trig && e) begin
                    m_mode = 1; m_elapsed = 0; m_used = 0;
                end
                1: if (p || !e) m_mode = 0;
                   else if (z && m_used < int'(MaxSn)) begin
                       m_mode = 2; m_elapsed = 0; m_used++;
                   end else if (t) begin
                       if (m_elapsed + 1 == int'(Ring)) m_mode = 0;
                       else m_elapsed++;
                   end
                default: if (p || !e) m_mode = 0;
                   else if (t) begin
                       if (m_elapsed + 1 == int'(Snz)) begin
                           m_mode = 1; m_elapsed = 0;
                       end else m_elapsed++;
                   end
            endcase
            m_prev = s;
        end
        x.buz      = (m_mode == 1) && (m_elapsed % 2 == 0);
        x.act      = (m_mode == 1);
        x.snoozing = (m_mode == 2);
        x.cnt      = 3'(m_used);
        exp_q.push_back(x);
        #1;
    endtask

    task automatic idle_cyc(input int n, input bit s, input bit e);
        for (int i = 0; i < n; i++) step(1, 0, s, e, 0, 0);
    endtask

    task automatic trig_ring();
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            idle_cyc(9, 1, 1);
            step(1, 1, 1, 1, 0, 0);
        end
    endtask

    bit r_snd, r_en;

    initial begin
        // Reset with match level held; no trigger at release until it falls and rises.
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        idle_cyc(3, 1, 1);
        trig_ring();
        // Ring timeout.
        ticks(Ring);
        idle_cyc(3, 1, 1);
        // Snooze cycle.
        trig_ring();
        step(1, 0, 1, 1, 1, 0);
        ticks(Snz);
        idle_cyc(2, 1, 1);
        // Snooze limit: second snooze, then a third press at the limit, then stop.
        step(1, 0, 1, 1, 1, 0);
        ticks(Snz);
        step(1, 0, 1, 1, 1, 0);
        ticks(1);
        step(1, 0, 1, 1, 0, 1);
        idle_cyc(3, 1, 1);
        // Disable while ringing, trigger while disabled, enable with level held.
        trig_ring();
        idle_cyc(2, 1, 0);
        idle_cyc(1, 0, 0);
        idle_cyc(2, 1, 0);
        idle_cyc(3, 1, 1);
        // Simultaneous events.
        trig_ring();
        step(1, 1, 1, 1, 1, 1);
        trig_ring();
        step(1, 1, 1, 1, 1, 0);
        ticks(1);
        step(1, 0, 1, 1, 0, 1);
        idle_cyc(2, 1, 1);
        // Randomized traffic with occasional reset.
        r_snd = 1'b0;
        r_en  = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 24) == 0) r_snd = ~r_snd;
            if ($urandom_range(0, 99) == 0) r_en = ~r_en;
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 4) == 0), r_snd, r_en,
                 ($urandom_range(0, 14) == 0), ($urandom_range(0, 59) == 0));
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Sequences the audible alarm downstream of the time/alarm comparator. It consumes the comparator's registered `sound_alarm` match level, which stays high for the whole matching minute, and turns its rising edge into a ringing session. A session has a 1 Hz beep pattern, a ring timeout, user snooze with a bounded repeat count, and a stop control. Its outputs drive the buzzer pin and the status LEDs.

## Interface
- `RING_SEC`, default 60: seconds of ringing before automatic shutoff; range 1..65535.
- `SNOOZE_SEC`, default 300: seconds in snooze before ringing resumes; range 1..65535.
- `MAX_SNOOZE`, default 3: maximum snoozes per session; range 0..7.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tick_1hz`  in  1  one-`clk`-cycle pulse once per second.
- `sound_alarm`  in  1  comparator match level (current time == alarm time).
- `alarm_en`  in  1  alarm armed switch, level.
- `snooze_btn`  in  1  debounced, one-cycle snooze pulse.
- `stop_btn`  in  1  debounced, one-cycle stop pulse.
- `buzzer`  out  1  tone enable, registered.
- `alarm_active`  out  1  high while in RINGING.
- `snoozing`  out  1  high while in SNOOZE.
- `snooze_cnt`  out  3  snoozes used in the current session.

## Operation
- The state is one of IDLE, RINGING or SNOOZE.
- Internal registers:
  - `snd_d`: previous `sound_alarm`.
  - `sec_cnt`: 16-bit seconds counter.
  - `beep`: beep phase bit.
  - `snooze_cnt`.
- Trigger = `sound_alarm & ~snd_d`. `snd_d` resets to 1, so a match level already present at reset release does not trigger; `sound_alarm` must fall and rise again.
- IDLE: on trigger with `alarm_en`=1, go to RINGING with `sec_cnt`=0, `snooze_cnt`=0, `beep`=1. A trigger seen while `alarm_en`=0 is discarded, not latched.
- RINGING, evaluated in this priority order each cycle:
  1. `stop_btn` goes to IDLE.
  2. `alarm_en`=0 goes to IDLE.
  3. `snooze_btn` with `snooze_cnt` < `MAX_SNOOZE` goes to SNOOZE, clears `sec_cnt` and increments `snooze_cnt`. A snooze press at the limit is ignored and ringing continues.
  4. On `tick_1hz`, if `sec_cnt` == `RING_SEC`-1, go to IDLE (timeout). Otherwise increment `sec_cnt` and toggle `beep`.
- SNOOZE:
  - `stop_btn` or `alarm_en`=0 goes to IDLE.
  - On `tick_1hz`, if `sec_cnt` == `SNOOZE_SEC`-1, go to RINGING with `sec_cnt`=0 and `beep`=1. Otherwise increment `sec_cnt`.
  - `snooze_btn` is ignored.
- Triggers arriving while in RINGING or SNOOZE are ignored. `snd_d` still tracks `sound_alarm` every cycle.
- `snooze_cnt` keeps its value in IDLE until the next session starts. It saturates at `MAX_SNOOZE` and never wraps.
- Output decode:
  - `buzzer` = (next state == RINGING) & next `beep`, registered.
  - `alarm_active` = state==RINGING.
  - `snoozing` = state==SNOOZE.

## Timing
- Reset (`rst_n` low at a `clk` edge) sets:
  - state IDLE;
  - `buzzer`, `alarm_active`, `snoozing` = 0;
  - `snooze_cnt`=0, `sec_cnt`=0, `beep`=0;
  - `snd_d`=1.
- Reset wins over every other input, including mid-session.
- Latency: if `sound_alarm` is first sampled high at edge E, `alarm_active` and `buzzer` are 1 after edge E. The pulse that follows the comparator is one cycle deep.
- Button response: `stop_btn` or `snooze_btn` sampled at edge E takes effect on outputs after edge E, and `buzzer` is 0 from then on.
- Ringing length: exactly `RING_SEC` ticks. `buzzer` is high for ticks 0,2,4… (on/off alternating per second).
- Snooze length: exactly `SNOOZE_SEC` ticks from entry.
- A tick that coincides with a button press is consumed by the button transition and does not count.

## Test plan
Unless noted, tests use `RING_SEC`=4, `SNOOZE_SEC`=3, `MAX_SNOOZE`=2.

- **Reset:** hold `rst_n`=0 for 2 cycles with `sound_alarm`=1, then release with `sound_alarm` still 1. Required: all outputs stay 0. Then drop `sound_alarm` for 1 cycle and raise it again: `alarm_active`=1 and `buzzer`=1 on the next edge.
- **Ring timeout:** trigger, then 4 ticks 10 cycles apart. Required: `buzzer` reads 1,0,1,0 across the tick intervals; `alarm_active` falls at the 4th tick; `snooze_cnt`=0.
- **Snooze cycle:** trigger, `snooze_btn`, then 3 ticks. Required: `snoozing`=1 and `snooze_cnt`=1 after the press; RINGING resumes with `buzzer`=1 at the 3rd tick.
- **Snooze limit:** snooze twice (`snooze_cnt`=2), then a third `snooze_btn` while ringing. Required: it is ignored and ringing continues. Then `stop_btn`: IDLE, with `snooze_cnt` holding 2.
- **Disable:** `alarm_en`=0 while ringing goes to IDLE next edge. A trigger with `alarm_en`=0 leaves outputs at 0. Raising `alarm_en` while `sound_alarm` stays high does not trigger.
- **Simultaneous events:** `stop_btn`, `snooze_btn` and `tick_1hz` in the same cycle go to IDLE. `snooze_btn` with `tick_1hz` goes to SNOOZE with `sec_cnt`=0. `stop_btn` during SNOOZE goes to IDLE.
